pc_sequencer: RTL

- Fetch-side instruction sequencer for the 4-bit CPU.
- Latches each 8-bit ROM word from the shared data bus during subcycles 3/4 and tracks one- vs two-word instructions.
- Decodes the PC-affecting opcodes (JCN, FIM, JIN, JUN, JMS, ISZ, BBL).
- Drives the pc_stack control/target inputs so that jumps, calls and returns commit at the end of the instruction cycle.
- Sits in cpu between cpu_control (cycle counter) and pc_stack; supplies latched opr/opa to execute logic.

---
 rtl/cpu_defs.sv | 39 +++
 rtl/jcn_cond.sv | 16 +
 rtl/pc_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the 4-bit CPU: pc_stack control encodings, opcode
// constants, subcycle indices and the one-/two-word instruction classifier.
package cpu_defs;

    typedef enum logic [1:0] {
        PC_NEXT = 2'b00,
        PC_JUMP = 2'b01,
        PC_CALL = 2'b10,
        PC_RET  = 2'b11
    } pc_control_t;

    typedef enum logic {
        SEQ_FIRST  = 1'b0,
        SEQ_SECOND = 1'b1
    } seq_state_t;

    localparam logic [3:0] OPR_JCN     = 4'b0001;
    localparam logic [3:0] OPR_FIM_SRC = 4'b0010;
    localparam logic [3:0] OPR_FIN_JIN = 4'b0011;
    localparam logic [3:0] OPR_JUN     = 4'b0100;
    localparam logic [3:0] OPR_JMS     = 4'b0101;
    localparam logic [3:0] OPR_ISZ     = 4'b0111;
    localparam logic [3:0] OPR_BBL     = 4'b1100;

    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    // FIM shares its opr with SRC; only the even-opa form carries a data word.
    function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
        case (opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: is_two_word = 1'b1;
            OPR_FIM_SRC:                        is_two_word = ~opa[0];
            default:                            is_two_word = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jcn_cond.sv
// JCN condition evaluator: opa[3] inverts the OR of the selected flags
// (opa[2] accumulator zero, opa[1] carry, opa[0] TEST pin low).
module jcn_cond (
    input  logic [3:0] opa,
    input  logic       acc_zero,
    input  logic       carry,
    input  logic       test,
    output logic       cond
);

    logic any_hit;

    assign any_hit = (opa[2] & acc_zero) | (opa[1] & carry) | (opa[0] & ~test);
    assign cond    = opa[3] ^ any_hit;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side instruction sequencer: latches opcode/operand words from the bus
// and issues registered pc_stack commands for subcycle 7 of each cycle.
module pc_sequencer
    import cpu_defs::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  cycle,
    input  logic [3:0]  data,
    input  logic        test,
    input  logic        acc_zero,
    input  logic        carry,
    input  logic        isz_nonzero,
    input  logic [7:0]  pair_value,
    input  logic [3:0]  pc_page,
    output logic [1:0]  pc_control,
    output logic [11:0] target,
    output logic [3:0]  opr,
    output logic [3:0]  opa,
    output logic        second_word
);

    seq_state_t  state_q, state_d;
    logic [3:0]  opr_q, opr_d;
    logic [3:0]  opa_q, opa_d;
    logic [7:0]  operand_q, operand_d;
    pc_control_t pc_control_q, pc_control_d;
    logic [11:0] target_q, target_d;
    logic        jcn_taken;

    jcn_cond u_jcn_cond (
        .opa      (opa_q),
        .acc_zero (acc_zero),
        .carry    (carry),
        .test     (test),
        .cond     (jcn_taken)
    );

    // Conditions and pc_page are consumed only at the edge ending subcycle 6,
    // so the command is stable through subcycle 7 regardless of input changes.
    always_comb begin
        state_d      = state_q;
        opr_d        = opr_q;
        opa_d        = opa_q;
        operand_d    = operand_q;
        pc_control_d = pc_control_q;
        target_d     = target_q;
        case (cycle)
            CYC_M1: begin
                if (state_q == SEQ_FIRST) opr_d = data;
                else                      operand_d[7:4] = data;
            end
            CYC_M2: begin
                if (state_q == SEQ_FIRST) opa_d = data;
                else                      operand_d[3:0] = data;
            end
            CYC_X2: begin
                pc_control_d = PC_NEXT;
                if (state_q == SEQ_FIRST) begin
                    if (opr_q == OPR_FIN_JIN && opa_q[0]) begin
                        pc_control_d = PC_JUMP;
                        target_d     = {pc_page, pair_value};
                    end else if (opr_q == OPR_BBL) begin
                        pc_control_d = PC_RET;
                    end
                end else begin
                    case (opr_q)
                        OPR_JUN: begin
                            pc_control_d = PC_JUMP;
                            target_d     = {opa_q, operand_q};
                        end
                        OPR_JMS: begin
                            pc_control_d = PC_CALL;
                            target_d     = {opa_q, operand_q};
                        end
                        OPR_JCN: begin
                            if (jcn_taken) begin
                                pc_control_d = PC_JUMP;
                                target_d     = {pc_page, operand_q};
                            end
                        end
                        OPR_ISZ: begin
                            if (isz_nonzero) begin
                                pc_control_d = PC_JUMP;
                                target_d     = {pc_page, operand_q};
                            end
                        end
                        default: pc_control_d = PC_NEXT;
                    endcase
                end
            end
            CYC_X3: begin
                pc_control_d = PC_NEXT;
                if (state_q == SEQ_FIRST && is_two_word(opr_q, opa_q)) state_d = SEQ_SECOND;
                else                                                    state_d = SEQ_FIRST;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= SEQ_FIRST;
            opr_q        <= 4'h0;
            opa_q        <= 4'h0;
            operand_q    <= 8'h00;
            pc_control_q <= PC_NEXT;
            target_q     <= 12'h000;
        end else begin
            state_q      <= state_d;
            opr_q        <= opr_d;
            opa_q        <= opa_d;
            operand_q    <= operand_d;
            pc_control_q <= pc_control_d;
            target_q     <= target_d;
        end
    end

    assign pc_control  = pc_control_q;
    assign target      = target_q;
    assign opr         = opr_q;
    assign opa         = opa_q;
    assign second_word = (state_q == SEQ_SECOND);

endmodule
